doled_rx: RTL
=============

DOLED_RX -- requirements
Module: doled_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on sck and mosi.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: idle clocks without an sck rising edge that abort a frame.
REQ-003 SHALL have parameter MAX_LEDS, default 2209 (47 strings x 47 LEDs): LED words accepted per frame.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- doled_rx_clk  input  1  system clock; all logic on its rising edge.
- doled_rx_reset_n  input  1  asynchronous active-low reset.
- sck  input  1  strip serial clock; asynchronous to doled_rx_clk.
- mosi  input  1  strip serial data, MSB first.
- led_valid  output  1  one-cycle pulse: LED word decoded.
- led_index  output  12  zero-based LED position within the current frame.
- brightness_out  output  5  global-brightness field.
- blue_out, green_out, red_out  output  8 each  colour bytes.
- frame_start  output  1  one-cycle pulse: start frame detected.
- frame_end  output  1  one-cycle pulse: end frame detected.
- frame_error  output  1  one-cycle pulse: malformed word, timeout or overflow.
- led_count  output  12  LED words in the last completed frame.

Function
REQ-005 SHALL pass sck and mosi through SYNC_STAGES flops; a bit SHALL be sampled when the synchronized sck goes 0->1, using the synchronized mosi of that same cycle.
REQ-006 SHALL support any sck high or low time of at least 4 doled_rx_clk cycles.
REQ-007 SHALL shift bits MSB first into a 32-bit shift register and count bits with a 5-bit counter.
REQ-008 State HUNT SHALL compare the shift register every sampled bit; 32 consecutive zeros SHALL pulse frame_start, clear the bit counter and led_index, and enter FRAME.
REQ-009 In FRAME, every 32nd bit SHALL complete a word, classified exactly once as follows.
REQ-010 Word bits[31:29]=111 and word not all ones SHALL be an LED word: brightness_out=[28:24], blue_out=[23:16], green_out=[15:8], red_out=[7:0].
REQ-011 For an LED word, led_index SHALL hold the current position and led_valid SHALL pulse for one cycle, both within 2 cycles of the 32nd sampling edge; led_index SHALL then increment.
REQ-012 A word of all ones SHALL pulse frame_end, load led_count with the LED words decoded, and enter HUNT.
REQ-013 A word of all zeros SHALL be a restart: pulse frame_start, clear led_index, stay in FRAME, and leave led_count unchanged.
REQ-014 Any other word, with bits[31:29] not 111, SHALL pulse frame_error and enter HUNT; the shift register SHALL be kept so that a start frame can be detected on the next bit.
REQ-015 LED word number MAX_LEDS+1 SHALL pulse frame_error without led_valid and enter HUNT.
REQ-016 In FRAME, TIMEOUT_CYCLES consecutive cycles without an sck rising edge SHALL pulse frame_error, discard any partial word and enter HUNT.
REQ-017 In HUNT, a timeout SHALL have no effect.
REQ-018 Colour and brightness outputs SHALL hold their last value between led_valid pulses.
REQ-019 At most one of frame_start, frame_end and frame_error SHALL pulse in any cycle.
REQ-020 The idle counter SHALL saturate and never wrap.

Reset
REQ-021 Asserting doled_rx_reset_n low SHALL immediately clear the state (HUNT), shift register, bit counter, idle counter, synchronizers, led_index, led_count and all colour/brightness outputs to 0.
REQ-022 While doled_rx_reset_n is low, all pulse outputs SHALL be 0.
REQ-023 Reset asserted mid-word SHALL discard the partial word; after reset is released, a new start frame SHALL be required before any LED word is decoded.
REQ-024 Reset release SHALL be synchronized to doled_rx_clk.

Structure
REQ-025 The shared LED-strip package SHALL hold: frame constants (START_WORD=32'h0, END_WORD=32'hFFFFFFFF, LED header 3'b111), the state enumeration, STRING_SIZE=47 and NUMBER_STRINGS=47.
REQ-026 The synchronizer plus rising-edge detector SHALL be one sub-module, named doled_rx_sync, instantiated once for sck and once for mosi; the state machine SHALL remain in doled_rx.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Start frame, LED words E5_10_20_30 and FF_01_02_03, end frame -> frame_start; led_valid at index 0 (br=5, b=10, g=20, r=30) and index 1 (br=31, b=01, g=02, r=03); frame_end; led_count=2.
- 2209 LED words then end frame -> 2209 led_valid pulses, indices 0..2208; led_count=2209.
- Word 0x5A000000 after start frame -> frame_error; next start frame resyncs.
- 2210th LED word -> frame_error, no led_valid.
- sck stopped for 4096 cycles after 17 bits of an LED word -> frame_error, no led_valid.
- Reset pulsed mid-word, then LED word without start frame -> no led_valid; outputs read 0.

Source files
------------

// File: rtl/doled_rx_pkg.sv
// Shared LED-strip definitions: frame constants, receiver states and strip geometry.
package doled_rx_pkg;

  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
  localparam logic [2:0]  LED_HEADER = 3'b111;

  localparam int STRING_SIZE    = 47;
  localparam int NUMBER_STRINGS = 47;
  localparam int LED_IDX_W      = 12;

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } rx_state_e;

endpackage

// File: rtl/doled_rx_sync.sv
// Multi-flop synchronizer for one asynchronous strip line, with a rising-edge strobe.
module doled_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: every flop in a clocked block uses <= so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/doled_rx.sv
// LED-strip frame receiver: hunts for the start frame, then decodes 32-bit LED words
// until an end frame, a malformed word, an overflow or an sck timeout.
module doled_rx import doled_rx_pkg::*; #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_LEDS       = STRING_SIZE * NUMBER_STRINGS
) (
  input  logic                 doled_rx_clk,
  input  logic                 doled_rx_reset_n,
  input  logic                 sck,
  input  logic                 mosi,
  output logic                 led_valid,
  output logic [LED_IDX_W-1:0] led_index,
  output logic [4:0]           brightness_out,
  output logic [7:0]           blue_out,
  output logic [7:0]           green_out,
  output logic [7:0]           red_out,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 frame_error,
  output logic [LED_IDX_W-1:0] led_count
);

  localparam int                   IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [LED_IDX_W-1:0] LED_LIMIT = LED_IDX_W'(MAX_LEDS);

  // Reset asserts immediately but releases only on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge doled_rx_clk or negedge doled_rx_reset_n) begin
    if (!doled_rx_reset_n) r_rst_sync <= 2'b00;
    else                   r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic w_sck_rise, w_sck_sync_unused;
  logic w_mosi_sync, w_mosi_rise_unused;

  doled_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk     (doled_rx_clk),
    .rst_n   (w_rst_n),
    .i_async (sck),
    .o_sync  (w_sck_sync_unused),
    .o_rise  (w_sck_rise)
  );

  doled_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk     (doled_rx_clk),
    .rst_n   (w_rst_n),
    .i_async (mosi),
    .o_sync  (w_mosi_sync),
    .o_rise  (w_mosi_rise_unused)
  );

  rx_state_e         r_state;
  logic [31:0]       r_shift;
  logic [4:0]        r_bit_cnt;
  logic [IDLE_W-1:0] r_idle;
  logic              r_hunt_full;  // shift register holds 32 real bits since last clear
  logic [31:0]       w_shift_next;

  assign w_shift_next = {r_shift[30:0], w_mosi_sync};

  always_ff @(posedge doled_rx_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state        <= HUNT;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_idle         <= '0;
      r_hunt_full    <= 1'b0;
      led_valid      <= 1'b0;
      led_index      <= '0;
      led_count      <= '0;
      brightness_out <= '0;
      blue_out       <= '0;
      green_out      <= '0;
      red_out        <= '0;
      frame_start    <= 1'b0;
      frame_end      <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      led_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_error <= 1'b0;

      if (w_sck_rise)              r_idle <= '0;
      else if (r_idle != IDLE_MAX) r_idle <= r_idle + IDLE_W'(1);

      // Index advances the cycle after its LED word is presented.
      if (led_valid) led_index <= led_index + LED_IDX_W'(1);

      unique case (r_state)
        HUNT: begin
          if (w_sck_rise) begin
            r_shift <= w_shift_next;
            if (!r_hunt_full) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd31) r_hunt_full <= 1'b1;
            end
            if ((r_hunt_full || r_bit_cnt == 5'd31) && w_shift_next == START_WORD) begin
              frame_start <= 1'b1;
              r_bit_cnt   <= '0;
              led_index   <= '0;
              r_state     <= FRAME;
            end
          end
        end

        FRAME: begin
          if (w_sck_rise) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd31) begin
              r_hunt_full <= 1'b1;
              if (w_shift_next == END_WORD) begin
                frame_end <= 1'b1;
                led_count <= led_index;
                r_state   <= HUNT;
              end else if (w_shift_next == START_WORD) begin
                frame_start <= 1'b1;
                led_index   <= '0;
              end else if (w_shift_next[31:29] == LED_HEADER && led_index != LED_LIMIT) begin
                led_valid      <= 1'b1;
                brightness_out <= w_shift_next[28:24];
                blue_out       <= w_shift_next[23:16];
                green_out      <= w_shift_next[15:8];
                red_out        <= w_shift_next[7:0];
              end else begin
                // Malformed word or one LED word too many.
                frame_error <= 1'b1;
                r_state     <= HUNT;
              end
            end
          end else if (r_idle == IDLE_LAST) begin
            frame_error <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_hunt_full <= 1'b0;
            r_state     <= HUNT;
          end
        end
      endcase
    end
  end

endmodule
